// File: rtl/label_stat_reader_pkg.sv
// Shared geometry, label constants, FSM states and the per-label record layout
// used by the label statistics reader.
package label_stat_reader_pkg;

    localparam int unsigned IMG_W      = 32;
    localparam int unsigned IMG_H      = 32;
    localparam int unsigned LABEL_W    = 4;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned X_W        = $clog2(IMG_W);
    localparam int unsigned Y_W        = $clog2(IMG_H);
    localparam int unsigned AREA_W     = ADDR_W + 1;
    localparam int unsigned NUM_LABELS = 2 ** LABEL_W;
    localparam int unsigned NUM_PIX    = IMG_W * IMG_H;

    localparam logic [LABEL_W-1:0] BG_LABEL   = '0;
    localparam logic [LABEL_W-1:0] LAST_LABEL = '1;

    // Bounding-box seeds: any real pixel shrinks min / grows max
    localparam logic [X_W-1:0] XMIN_RST = X_W'(IMG_W - 1);
    localparam logic [X_W-1:0] XMAX_RST = '0;
    localparam logic [Y_W-1:0] YMIN_RST = Y_W'(IMG_H - 1);
    localparam logic [Y_W-1:0] YMAX_RST = '0;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        REPORT,
        DONE
    } state_t;

    typedef struct packed {
        logic [LABEL_W-1:0] label;
        logic [AREA_W-1:0]  area;
        logic [X_W-1:0]     xmin;
        logic [X_W-1:0]     xmax;
        logic [Y_W-1:0]     ymin;
        logic [Y_W-1:0]     ymax;
    } stat_rec_t;

endpackage

// File: rtl/label_stat_acc.sv
// Per-label accumulator bank: pixel area and inclusive bounding box for every
// label, with synchronous clear, single-pixel update and combinational read.
module label_stat_acc
    import label_stat_reader_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               upd,
    input  logic [LABEL_W-1:0] upd_label,
    input  logic [X_W-1:0]     upd_x,
    input  logic [Y_W-1:0]     upd_y,
    input  logic [LABEL_W-1:0] rd_idx,
    output stat_rec_t          rd_rec_c
);

    logic [AREA_W-1:0] area [NUM_LABELS];
    logic [X_W-1:0]    xmin [NUM_LABELS];
    logic [X_W-1:0]    xmax [NUM_LABELS];
    logic [Y_W-1:0]    ymin [NUM_LABELS];
    logic [Y_W-1:0]    ymax [NUM_LABELS];

    // Background entries are never written, so entry 0 stays at its seed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LABELS; i++) begin
                area[i] <= '0;
                xmin[i] <= XMIN_RST;
                xmax[i] <= XMAX_RST;
                ymin[i] <= YMIN_RST;
                ymax[i] <= YMAX_RST;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_LABELS; i++) begin
                area[i] <= '0;
                xmin[i] <= XMIN_RST;
                xmax[i] <= XMAX_RST;
                ymin[i] <= YMIN_RST;
                ymax[i] <= YMAX_RST;
            end
        end else if (upd && upd_label != BG_LABEL) begin
            area[upd_label] <= area[upd_label] + AREA_W'(1);
            if (upd_x < xmin[upd_label]) xmin[upd_label] <= upd_x;
            if (upd_x > xmax[upd_label]) xmax[upd_label] <= upd_x;
            if (upd_y < ymin[upd_label]) ymin[upd_label] <= upd_y;
            if (upd_y > ymax[upd_label]) ymax[upd_label] <= upd_y;
        end
    end

    always_comb begin
        rd_rec_c       = '0;
        rd_rec_c.label = rd_idx;
        rd_rec_c.area  = area[rd_idx];
        rd_rec_c.xmin  = xmin[rd_idx];
        rd_rec_c.xmax  = xmax[rd_idx];
        rd_rec_c.ymin  = ymin[rd_idx];
        rd_rec_c.ymax  = ymax[rd_idx];
    end

endmodule

// File: rtl/label_stat_reader.sv
// Scans the 32x32 label SRAM once per start, then streams one area/bounding-box
// record per non-empty label in ascending label order over valid/ready.
module label_stat_reader
    import label_stat_reader_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  sram_a,
    output logic               sram_wen,
    input  logic [7:0]         sram_q,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LABEL_W-1:0] out_label,
    output logic [AREA_W-1:0]  out_area,
    output logic [X_W-1:0]     out_xmin,
    output logic [X_W-1:0]     out_xmax,
    output logic [Y_W-1:0]     out_ymin,
    output logic [Y_W-1:0]     out_ymax,
    output logic               done
);

    state_t             state, next_state;
    logic [LABEL_W-1:0] idx, idx_nxt;
    logic [ADDR_W-1:0]  sram_a_nxt;
    logic               out_valid_nxt, busy_nxt, done_nxt;
    stat_rec_t          out_rec, out_rec_nxt, rd_rec_c;
    logic               clear_c, advance_c, upd_c;
    logic               valid_d;
    logic [X_W-1:0]     x_d;
    logic [Y_W-1:0]     y_d;
    logic               unused_hi;

    assign sram_wen  = 1'b1;
    assign unused_hi = ^sram_q[7:LABEL_W];
    assign upd_c     = valid_d && (sram_q[LABEL_W-1:0] != BG_LABEL);
    // An index is finished when it is empty or its record has just been taken
    assign advance_c = (rd_rec_c.area == '0) || (out_valid && out_ready);

    label_stat_acc u_acc (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear_c),
        .upd       (upd_c),
        .upd_label (sram_q[LABEL_W-1:0]),
        .upd_x     (x_d),
        .upd_y     (y_d),
        .rd_idx    (idx),
        .rd_rec_c  (rd_rec_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SCAN;
            SCAN:    if (sram_a == ADDR_W'(NUM_PIX - 1)) next_state = DRAIN;
            DRAIN:   next_state = REPORT;
            REPORT:  if (advance_c && idx == LAST_LABEL) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sram_a_nxt    = sram_a;
        idx_nxt       = idx;
        out_valid_nxt = out_valid;
        out_rec_nxt   = out_rec;
        clear_c       = 1'b0;
        case (state)
            IDLE: if (start) begin
                clear_c    = 1'b1;
                sram_a_nxt = '0;
            end
            SCAN:  sram_a_nxt = sram_a + ADDR_W'(1);
            DRAIN: idx_nxt    = LABEL_W'(1);
            REPORT: begin
                if (advance_c) begin
                    idx_nxt       = idx + LABEL_W'(1);
                    out_valid_nxt = 1'b0;
                end else if (!out_valid) begin
                    out_valid_nxt = 1'b1;
                    out_rec_nxt   = rd_rec_c;
                end
            end
            default: ;
        endcase
        busy_nxt = (next_state == SCAN) || (next_state == DRAIN) || (next_state == REPORT);
        done_nxt = (next_state == DONE);
    end

    // Output and datapath registers; the delayed {valid,x,y} lines up with sram_q
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_a    <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_rec   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid_d   <= 1'b0;
            x_d       <= '0;
            y_d       <= '0;
        end else begin
            sram_a    <= sram_a_nxt;
            idx       <= idx_nxt;
            out_valid <= out_valid_nxt;
            out_rec   <= out_rec_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            valid_d   <= (state == SCAN);
            x_d       <= sram_a[X_W-1:0];
            y_d       <= sram_a[ADDR_W-1:X_W];
        end
    end

    assign out_label = out_rec.label;
    assign out_area  = out_rec.area;
    assign out_xmin  = out_rec.xmin;
    assign out_xmax  = out_rec.xmax;
    assign out_ymin  = out_rec.ymin;
    assign out_ymax  = out_rec.ymax;

endmodule

// File: tb/tb_label_stat_reader.sv
// Directed bench for label_stat_reader: SRAM model with one-cycle read latency,
// hand-computed records, timing, backpressure, ignored start and mid-scan reset.
module tb_label_stat_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [9:0]  sram_a;
    logic        sram_wen;
    logic [7:0]  sram_q;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_label;
    logic [10:0] out_area;
    logic [4:0]  out_xmin, out_xmax, out_ymin, out_ymax;
    logic        done;

    logic [7:0]  mem [1024];
    logic [34:0] exp_q[$];
    logic [34:0] got_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) sram_q <= mem[sram_a];

    label_stat_reader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .sram_a    (sram_a),
        .sram_wen  (sram_wen),
        .sram_q    (sram_q),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_label (out_label),
        .out_area  (out_area),
        .out_xmin  (out_xmin),
        .out_xmax  (out_xmax),
        .out_ymin  (out_ymin),
        .out_ymax  (out_ymax),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] mk(input int l, input int a, input int x0, input int x1,
                                       input int y0, input int y1);
        return {4'(l), 11'(a), 5'(x0), 5'(x1), 5'(y0), 5'(y1)};
    endfunction

    function automatic logic [34:0] cur_rec();
        return {out_label, out_area, out_xmin, out_xmax, out_ymin, out_ymax};
    endfunction

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 1024; i++) mem[i] = v;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "/sram_a"},    sram_a,    0);
        check({name, "/sram_wen"},  sram_wen,  1);
        check({name, "/busy"},      busy,      0);
        check({name, "/out_valid"}, out_valid, 0);
        check({name, "/fields"},    cur_rec(), 0);
        check({name, "/done"},      done,      0);
    endtask

    // One full scan/report; stall = ready-low cycles on first record, poke = cycle of a stray start
    task automatic run(input string name, input int stall, input int poke);
        int cyc, done_cyc, left;
        logic [34:0] snap;
        bit snapped;
        got_q.delete();
        left = stall; snapped = 0; done_cyc = -1; snap = '0;
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        while (done_cyc < 0 && cyc < 2000) begin
            if (cyc == 1)    check({name, "/busy_first"}, busy, 1);
            if (cyc == 1040) check({name, "/busy_late"},  busy, 1);
            start = (cyc == poke);
            if (done) begin
                done_cyc = cyc;
                check({name, "/busy_at_done"}, busy, 0);
            end else if (out_valid) begin
                if (left > 0) begin
                    if (!snapped) begin snap = cur_rec(); snapped = 1; end
                    else check({name, "/stable"}, cur_rec(), snap);
                    out_ready = 1'b0; left--;
                end else begin
                    out_ready = 1'b1;
                    got_q.push_back(cur_rec());
                end
            end else begin
                out_ready = 1'b1;
            end
            if (done_cyc < 0) begin @(negedge clk); cyc++; end
        end
        start = 1'b0; out_ready = 1'b1;
        check({name, "/done_cycle"}, done_cyc, 1041 + exp_q.size() + stall);
        check({name, "/nrec"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s/rec%0d", name, i), got_q[i], exp_q[i]);
        @(negedge clk);
        check({name, "/done_pulse"}, done, 0);
        check({name, "/idle_busy"}, busy, 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        fill(8'h00);
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // All background
        exp_q.delete();
        run("empty", 0, 0);

        // Single pixel, label 3 at (5,7)
        fill(8'h00); mem[229] = 8'h03;
        exp_q.delete(); exp_q.push_back(mk(3, 1, 5, 5, 7, 7));
        run("single", 0, 0);

        // Stray start during SCAN is ignored
        run("poke", 0, 300);

        // Full image label 1, clean and with upper-nibble garbage
        fill(8'h01);
        exp_q.delete(); exp_q.push_back(mk(1, 1024, 0, 31, 0, 31));
        run("full", 0, 0);
        fill(8'hF1);
        run("full_hi", 0, 0);

        // Labels 2 and 9 with 5-cycle backpressure on the first record
        fill(8'h00);
        for (int y = 0; y < 2; y++)
            for (int x = 10; x < 13; x++) mem[y * 32 + x] = 8'h02;
        mem[31 * 32 + 31] = 8'h09;
        mem[20 * 32 + 0]  = 8'h09;
        exp_q.delete();
        exp_q.push_back(mk(2, 6, 10, 12, 0, 1));
        exp_q.push_back(mk(9, 2, 0, 31, 20, 31));
        run("two_bp", 5, 0);

        // Reset in SCAN cycle 500, then a clean rerun
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (499) @(negedge clk);
        check("pre_reset/busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset/out_valid", out_valid, 0);
        run("after_reset", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
